// File: rtl/lsu_mlbmiss_replay.sv
// lsu_mlbmiss_replay: MLB-miss queue that walks each head entry's page, then replays it into address-calc.
// Optional LSU_MISS_COALESCE_EN: one successful walk also marks matching queued entries as walked.
`default_nettype none

module lsu_mlbmiss_replay #(
  parameter int DEPTH  = 4,
  parameter int PWIDTH = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic              miss_en,
  input  logic [43:0]       miss_addr,
  input  logic [3:0]        miss_attr,
  input  logic              miss_thread,
  input  logic              bus_hold,
  output logic              walk_req,
  output logic [PWIDTH-1:0] walk_page,
  output logic              walk_thread,
  input  logic              walk_ack,
  input  logic              walk_fault,
  output logic              mex_en,
  output logic [43:0]       mex_addr,
  output logic [3:0]        mex_attr,
  output logic              fault_en,
  output logic              fault_thread,
  output logic              miss_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WALK, REPLAY, DRAIN} state_t;

  state_t            state, state_d;
  logic [43:0]       addr_q [DEPTH];
  logic [3:0]        attr_q [DEPTH];
  logic [DEPTH-1:0]  thread_q;
  logic [DEPTH-1:0]  walked_q;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic full, empty, push, pop, drop;
  logic walk_start, walk_ok, mex_fire, fault_fire;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A full queue still accepts a miss when the head leaves in the same cycle.
  assign push  = miss_en & ~except & (~full | pop);
  assign drop  = miss_en & ~except & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    walk_start = 1'b0;
    walk_ok    = 1'b0;
    mex_fire   = 1'b0;
    fault_fire = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (walked_q[rd_ptr]) begin
            state_d = REPLAY;
          end else begin
            state_d    = WALK;
            walk_start = 1'b1;
          end
        end
      end
      WALK: begin
        if (walk_ack) begin
          if (walk_fault) begin
            pop        = 1'b1;
            fault_fire = 1'b1;
            state_d    = IDLE;
          end else begin
            walk_ok = 1'b1;
            state_d = REPLAY;
          end
        end
      end
      REPLAY: begin
        if (!bus_hold) begin
          pop      = 1'b1;
          mex_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        if (walk_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A walk still in flight must be drained so its ack is not credited to a later walk.
    if (except) begin
      pop        = 1'b0;
      walk_start = 1'b0;
      walk_ok    = 1'b0;
      mex_fire   = 1'b0;
      fault_fire = 1'b0;
      state_d    = ((state == WALK || state == DRAIN) && !walk_ack) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || except) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[wr_ptr]   <= miss_addr;
      attr_q[wr_ptr]   <= miss_attr;
      thread_q[wr_ptr] <= miss_thread;
    end
  end

`ifdef LSU_MISS_COALESCE_EN
  logic [DEPTH-1:0] entry_valid;

  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, AW'(i) - rd_ptr} < count);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || except) begin
      walked_q <= '0;
    end else begin
      if (walk_ok) begin
`ifdef LSU_MISS_COALESCE_EN
        for (int i = 0; i < DEPTH; i++) begin
          if (entry_valid[i] && addr_q[i][13 +: PWIDTH] == walk_page && thread_q[i] == walk_thread)
            walked_q[i] <= 1'b1;
        end
`else
        walked_q[rd_ptr] <= 1'b1;
`endif
      end
      if (push) walked_q[wr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_req     <= 1'b0;
      walk_page    <= '0;
      walk_thread  <= 1'b0;
      mex_en       <= 1'b0;
      mex_addr     <= '0;
      mex_attr     <= '0;
      fault_en     <= 1'b0;
      fault_thread <= 1'b0;
      miss_drop    <= 1'b0;
    end else begin
      walk_req  <= (state_d == WALK);
      mex_en    <= mex_fire;
      fault_en  <= fault_fire;
      miss_drop <= drop;
      if (walk_start) begin
        walk_page   <= addr_q[rd_ptr][13 +: PWIDTH];
        walk_thread <= thread_q[rd_ptr];
      end
      if (mex_fire) begin
        mex_addr <= addr_q[rd_ptr];
        mex_attr <= attr_q[rd_ptr];
      end
      if (fault_fire) fault_thread <= thread_q[rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mlbmiss_replay.sv
// tb_lsu_mlbmiss_replay: directed and random stimulus checked against a queue-based reference model.
`default_nettype none

module tb_lsu_mlbmiss_replay;

  localparam int DEPTH = 4;
  localparam int PWIDTH = 31;
`ifdef LSU_MISS_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WALK = 1, M_REPLAY = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, except = 1'b0, miss_en = 1'b0, miss_thread = 1'b0, bus_hold = 1'b0;
  logic [43:0] miss_addr = '0;
  logic [3:0]  miss_attr = '0;
  logic walk_ack = 1'b0, walk_fault = 1'b0;
  logic walk_req, walk_thread, mex_en, fault_en, fault_thread, miss_drop;
  logic [PWIDTH-1:0] walk_page;
  logic [43:0] mex_addr;
  logic [3:0]  mex_attr;

  always #5 clk = ~clk;

  lsu_mlbmiss_replay #(.DEPTH(DEPTH), .PWIDTH(PWIDTH)) dut (
    .clk(clk), .rst(rst), .except(except), .miss_en(miss_en), .miss_addr(miss_addr),
    .miss_attr(miss_attr), .miss_thread(miss_thread), .bus_hold(bus_hold),
    .walk_req(walk_req), .walk_page(walk_page), .walk_thread(walk_thread),
    .walk_ack(walk_ack), .walk_fault(walk_fault), .mex_en(mex_en), .mex_addr(mex_addr),
    .mex_attr(mex_attr), .fault_en(fault_en), .fault_thread(fault_thread), .miss_drop(miss_drop)
  );

  typedef struct {
    logic [43:0] addr;
    logic [3:0]  attr;
    logic        thr;
    logic        walked;
  } ent_t;

  ent_t q[$];
  int   mst = M_IDLE;
  logic e_walk_req, e_walk_thread, e_mex_en, e_fault_en, e_fault_thread, e_miss_drop;
  logic [PWIDTH-1:0] e_walk_page;
  logic [43:0] e_mex_addr;
  logic [3:0]  e_mex_attr;

  int checks = 0, failures = 0;
  int walk_rises = 0, mex_cnt = 0, fault_cnt = 0, drop_cnt = 0;
  logic prev_walk_req = 1'b0;
  logic [43:0] mex_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: queue of pending misses plus the controller phase, advanced once per clock.
  task automatic model_update();
    int nst;
    bit pop_now;
    ent_t e;
    if (rst) begin
      q.delete();
      mst = M_IDLE;
      e_walk_req = 0; e_walk_page = '0; e_walk_thread = 0; e_mex_en = 0; e_mex_addr = '0;
      e_mex_attr = '0; e_fault_en = 0; e_fault_thread = 0; e_miss_drop = 0;
      return;
    end
    nst = mst; pop_now = 0;
    e_mex_en = 0; e_fault_en = 0; e_miss_drop = 0;
    if (except) begin
      q.delete();
      nst = ((mst == M_WALK || mst == M_DRAIN) && !walk_ack) ? M_DRAIN : M_IDLE;
    end else begin
      case (mst)
        M_IDLE: if (q.size() != 0) begin
          if (q[0].walked) nst = M_REPLAY;
          else begin
            nst = M_WALK;
            e_walk_page = q[0].addr[43:13];
            e_walk_thread = q[0].thr;
          end
        end
        M_WALK: if (walk_ack) begin
          if (walk_fault) begin
            e_fault_en = 1; e_fault_thread = q[0].thr; pop_now = 1; nst = M_IDLE;
          end else begin
            for (int i = q.size() - 1; i >= 0; i--)
              if (i == 0 || (COALESCE && q[i].addr[43:13] == q[0].addr[43:13] && q[i].thr == q[0].thr))
                q[i].walked = 1;
            nst = M_REPLAY;
          end
        end
        M_REPLAY: if (!bus_hold) begin
          e_mex_en = 1; e_mex_addr = q[0].addr; e_mex_attr = q[0].attr; pop_now = 1; nst = M_IDLE;
        end
        default: if (walk_ack) nst = M_IDLE;
      endcase
      if (pop_now) void'(q.pop_front());
      if (miss_en) begin
        if (q.size() < DEPTH) begin
          e.addr = miss_addr; e.attr = miss_attr; e.thr = miss_thread; e.walked = 0;
          q.push_back(e);
        end else e_miss_drop = 1;
      end
    end
    mst = nst;
    e_walk_req = (nst == M_WALK);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("walk_req", walk_req, e_walk_req);
    chk("walk_page", walk_page, e_walk_page);
    chk("walk_thread", walk_thread, e_walk_thread);
    chk("mex_en", mex_en, e_mex_en);
    chk("mex_addr", mex_addr, e_mex_addr);
    chk("mex_attr", mex_attr, e_mex_attr);
    chk("fault_en", fault_en, e_fault_en);
    chk("fault_thread", fault_thread, e_fault_thread);
    chk("miss_drop", miss_drop, e_miss_drop);
    if (walk_req && !prev_walk_req) walk_rises++;
    prev_walk_req = walk_req;
    if (mex_en) begin mex_cnt++; mex_log.push_back(mex_addr); end
    if (fault_en) fault_cnt++;
    if (miss_drop) drop_cnt++;
  endtask

  task automatic tick();
    step();
    miss_en = 0; walk_ack = 0; walk_fault = 0; except = 0;
  endtask

  task automatic miss(input logic [43:0] a, input logic [3:0] at, input logic th);
    miss_addr = a; miss_attr = at; miss_thread = th; miss_en = 1;
    tick();
  endtask

  task automatic wait_walk();
    for (int i = 0; i < 20 && !walk_req; i++) tick();
    chk("wait_walk_req", walk_req, 1);
  endtask

  // Acknowledge every walk request until `target` replays have been seen or the budget runs out.
  task automatic service(input int target);
    for (int i = 0; i < 200 && mex_cnt < target; i++) begin
      walk_ack = walk_req;
      tick();
    end
    chk("service_mex_cnt", mex_cnt, target);
  endtask

  initial begin
    int base, rises0;
    logic [43:0] addrs[4];

    // Reset overrides except, miss_en and walk_ack.
    except = 1; miss_en = 1; walk_ack = 1; miss_addr = 44'hFFF_FFFF_FFFF;
    step(); step();
    rst = 0; except = 0; miss_en = 0;
    tick();
    chk("rst_walk_req", walk_req, 0);
    chk("rst_mex_en", mex_en, 0);

    // Single miss: walk_req at cycle 2, ack 3 cycles later, replay 2 cycles after ack.
    miss(44'h123_4567_8ABC, 4'h5, 1'b0);
    tick();
    chk("lat_walk_req", walk_req, 1);
    chk("single_walk_page", walk_page, 31'h91A2B3C);
    tick(); tick(); tick();
    walk_ack = 1; tick();
    chk("ack_walk_req_low", walk_req, 0);
    chk("ack_no_mex_yet", mex_en, 0);
    tick();
    chk("lat_mex_en", mex_en, 1);
    chk("single_mex_addr", mex_addr, 44'h123_4567_8ABC);
    chk("single_mex_attr", mex_attr, 4'h5);
    tick();
    chk("single_mex_pulse", mex_en, 0);
    chk("single_mex_cnt", mex_cnt, 1);
    chk("single_queue_empty", q.size(), 0);

    // Five back-to-back misses into a 4-entry queue: fifth is dropped, four replay in order.
    base = drop_cnt;
    mex_log.delete();
    for (int i = 0; i < 4; i++) addrs[i] = 44'h0AB_0000_0000 + 44'(i) * 44'h4000;
    for (int i = 0; i < 4; i++) miss(addrs[i], 4'(i + 1), 1'b0);
    miss(44'h0CD_0000_0000, 4'hF, 1'b0);
    chk("overflow_drop", drop_cnt - base, 1);
    service(mex_cnt + 4);
    for (int i = 0; i < 4; i++) chk("overflow_order", mex_log[i], addrs[i]);

    // Faulting walk on thread 1; the next entry is walked afterwards.
    base = mex_cnt;
    miss(44'h001_1111_0000, 4'h3, 1'b1);
    miss(44'h002_2222_0000, 4'h4, 1'b0);
    wait_walk();
    chk("fault_walk_thread", walk_thread, 1);
    walk_ack = 1; walk_fault = 1; tick();
    chk("fault_en_hi", fault_en, 1);
    chk("fault_thread_val", fault_thread, 1);
    chk("fault_no_mex", mex_en, 0);
    tick();
    chk("fault_en_pulse", fault_en, 0);
    wait_walk();
    chk("fault_next_page", walk_page, 31'(44'h002_2222_0000 >> 13));
    service(base + 1);
    chk("fault_next_mex", mex_log[mex_log.size() - 1], 44'h002_2222_0000);

    // Exception while walking: queue flushed, later ack ignored.
    base = mex_cnt;
    miss(44'h003_3333_0000, 4'h6, 1'b0);
    wait_walk();
    except = 1; tick();
    chk("except_walk_req_low", walk_req, 0);
    tick(); tick();
    walk_ack = 1; tick();
    for (int i = 0; i < 5; i++) tick();
    chk("except_no_mex", mex_cnt - base, 0);

    // Three misses to page 0x2000, thread 0; replay held off by bus_hold for 5 cycles.
    base = mex_cnt;
    rises0 = walk_rises;
    for (int i = 0; i < 3; i++) miss(44'h2000 + 44'(i * 8), 4'(i + 1), 1'b0);
    wait_walk();
    bus_hold = 1;
    walk_ack = 1; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mex_off", mex_en, 0);
    end
    bus_hold = 0;
    service(base + 3);
    chk("same_page_walks", walk_rises - rises0, COALESCE ? 1 : 3);

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 800; n++) begin
      miss_en = ($urandom_range(0, 9) < 4);
      miss_addr = {31'($urandom_range(0, 3)), 13'($urandom)};
      miss_attr = 4'($urandom);
      miss_thread = 1'($urandom);
      walk_ack = walk_req ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      walk_fault = ($urandom_range(0, 3) == 0);
      bus_hold = ($urandom_range(0, 9) < 3);
      except = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      rst = 0;
    end
    bus_hold = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mlbmiss_replay.md
LSU_MLBMISS_REPLAY -- requirements
Module: lsu_mlbmiss_replay

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter PWIDTH, default 31, page-number width (address bits 43:13).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port except  input  1  pipeline flush.
REQ-006 SHALL have port miss_en  input  1  address-calc stage reports an MLB miss this cycle.
REQ-007 SHALL have port miss_addr  input  44  physical-stage address of the missing op.
REQ-008 SHALL have port miss_attr  input  4  attribute of the missing op.
REQ-009 SHALL have port miss_thread  input  1  thread of the missing op.
REQ-010 SHALL have port bus_hold  input  1  replay slot unavailable.
REQ-011 SHALL have port walk_req  output  1  page walk request, level.
REQ-012 SHALL have port walk_page  output  PWIDTH  head entry miss_addr[43:13].
REQ-013 SHALL have port walk_thread  output  1  head entry thread.
REQ-014 SHALL have port walk_ack  input  1  walk done, one-cycle pulse.
REQ-015 SHALL have port walk_fault  input  1  walk failed; valid with walk_ack.
REQ-016 SHALL have port mex_en, mex_addr[43:0], mex_attr[3:0]  output  replay request into address-calc stage.
REQ-017 SHALL have port fault_en  output  1  one-cycle walk-fault report; fault_thread  output  1 accompanies it.
REQ-018 SHALL have port miss_drop  output  1  one-cycle pulse: miss lost because queue full.

Function
REQ-019 SHALL hold a circular FIFO of DEPTH entries {addr, attr, thread, walked}; rd/wr pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-020 SHALL push on miss_en & ~except & count<DEPTH; entry valid next cycle; walked=0.
REQ-021 SHALL, on miss_en & ~except & count==DEPTH, discard the miss and pulse miss_drop the next cycle.
REQ-022 SHALL, on simultaneous push and pop, perform both; count unchanged; push legal at count==DEPTH only if pop occurs the same cycle.
REQ-023 SHALL run FSM IDLE, WALK, REPLAY, DRAIN; all outputs registered.
REQ-024 IDLE: count!=0 & head.walked=0 -> WALK, walk_req=1 from next cycle; count!=0 & head.walked=1 -> REPLAY.
REQ-025 WALK: hold walk_req, walk_page, walk_thread stable until walk_ack; walk_ack & ~walk_fault -> REPLAY, head.walked=1, walk_req=0 next cycle.
REQ-026 WALK: walk_ack & walk_fault -> pop head, fault_en=1 with fault_thread for one cycle, -> IDLE.
REQ-027 REPLAY: bus_hold=0 -> mex_en=1 for exactly one cycle with head addr/attr, pop, -> IDLE; bus_hold=1 -> stay, mex_en=0.
REQ-028 Latency with empty queue, no hold: miss_en cycle 0 -> walk_req high cycle 2; walk_ack cycle N -> mex_en high cycle N+2.
REQ-029 except: clear all entries, count=0, mex_en/fault_en forced 0 next cycle; from WALK -> DRAIN, else -> IDLE.
REQ-030 DRAIN: walk_req=0; wait for walk_ack, ignore its result, -> IDLE; pushes accepted in DRAIN.
REQ-031 except with miss_en same cycle: miss discarded, no miss_drop.

Reset
REQ-032 rst SHALL set state IDLE, pointers/count 0, all walked bits 0, walk_req, mex_en, fault_en, miss_drop 0, mex_addr, mex_attr, walk_page, walk_thread, fault_thread 0.
REQ-033 rst SHALL override except, miss_en and walk_ack in the same cycle; walk_ack after rst is ignored in IDLE.

Configuration
REQ-034 Macro LSU_MISS_COALESCE_EN SHALL, when defined, on successful walk_ack set walked=1 in every valid entry whose page and thread equal the head's, so those entries replay without a second walk.
REQ-035 Without LSU_MISS_COALESCE_EN, only the head's walked bit is set; every entry issues its own walk.

Verification
REQ-036 Single miss addr 0x123_4567_8ABC, attr 0x5, walk_ack 3 cycles after walk_req -> walk_page 0x91A2B3C, one mex_en with 0x123_4567_8ABC, attr 0x5, count returns 0.
REQ-037 Five misses back-to-back, DEPTH=4, no ack -> fifth pulses miss_drop; after four acks four mex_en in push order.
REQ-038 walk_ack with walk_fault, thread 1 -> fault_en one cycle, fault_thread=1, no mex_en, next entry walked.
REQ-039 except while walk_req high -> queue empty, walk_req low next cycle; later walk_ack ignored, no mex_en.
REQ-040 Three misses same page 0x2000 thread 0, bus_hold high 5 cycles in REPLAY -> mex_en held off then issued; with LSU_MISS_COALESCE_EN one walk_req total, without it three.
